// File: rtl/cdb_pkg.sv
// Shared types and constants for the Common Data Bus arbiter.
// The result struct fixes the tag/data widths used by cdb_arbiter's defaults.
package cdb_pkg;
  localparam int CDB_TAG_W  = 7;
  localparam int CDB_DATA_W = 32;

  localparam int REQ_INT  = 0;
  localparam int REQ_LW   = 1;
  localparam int REQ_MULT = 2;
  localparam int REQ_DIV  = 3;

  typedef struct packed {
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
    logic                  branch;
    logic                  taken;
  } cdb_result_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Produces a one-hot grant, the encoded winner and an any-grant flag.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          any
);
  always_comb begin : pick
    int j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = PW'(j);
      end
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: one-entry holding buffer per execution unit,
// round-robin grant, and registered CDB broadcast outputs.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = CDB_TAG_W,
  parameter int DATA_W  = CDB_DATA_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0][TAG_W-1:0]   req_tag,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_data,
  input  logic [NUM_REQ-1:0]              req_branch,
  input  logic [NUM_REQ-1:0]              req_branch_taken,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            cdb_valid,
  output logic [TAG_W-1:0]                cdb_tag,
  output logic [DATA_W-1:0]               cdb_data,
  output logic                            cdb_branch,
  output logic                            cdb_branch_taken
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  cdb_result_t [NUM_REQ-1:0] buf_q, buf_d;
  logic [NUM_REQ-1:0]        buf_valid_q, buf_valid_d;
  logic [NUM_REQ-1:0]        grant, accept;
  logic [PW-1:0]             ptr_q, ptr_d, gidx;
  logic                      gany;
  cdb_result_t               cdb_q, cdb_d;
  logic                      cdb_valid_q, cdb_valid_d;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req   (buf_valid_q),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (gidx),
    .any   (gany)
  );

  // A granted buffer drains this edge, so it can refill in the same cycle.
  assign req_ready = rst ? (~buf_valid_q | grant) : '0;
  assign accept    = req_valid & req_ready;

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_d       = buf_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      buf_valid_d[i] = accept[i] | (buf_valid_q[i] & ~grant[i]);
      if (accept[i])
        buf_d[i] = '{tag: req_tag[i], data: req_data[i],
                     branch: req_branch[i], taken: req_branch_taken[i]};
    end
  end

  always_comb begin
    cdb_valid_d = gany;
    cdb_d       = '0;
    ptr_d       = ptr_q;
    if (gany) begin
      cdb_d       = buf_q[gidx];
      cdb_d.taken = buf_q[gidx].branch & buf_q[gidx].taken;
      ptr_d       = (gidx == PW'(NUM_REQ-1)) ? '0 : gidx + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid_q <= '0;
      buf_q       <= '0;
      ptr_q       <= '0;
      cdb_valid_q <= 1'b0;
      cdb_q       <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_q       <= buf_d;
      ptr_q       <= ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_q       <= cdb_d;
    end
  end

  assign cdb_valid        = cdb_valid_q;
  assign cdb_tag          = cdb_q.tag;
  assign cdb_data         = cdb_q.data;
  assign cdb_branch       = cdb_q.branch;
  assign cdb_branch_taken = cdb_q.taken;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: per-unit result queues drive the handshake,
// and every CDB cycle is checked against hand-computed expectations.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int N = 4;

  logic                 clk, rst;
  logic [N-1:0]         req_valid, req_branch, req_branch_taken, req_ready;
  logic [N-1:0][6:0]    req_tag;
  logic [N-1:0][31:0]   req_data;
  logic                 cdb_valid, cdb_branch, cdb_branch_taken;
  logic [6:0]           cdb_tag;
  logic [31:0]          cdb_data;

  int compared   = 0;
  int mismatched = 0;

  cdb_result_t pend [N][16];
  int          wr [N];
  int          rd [N];

  cdb_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_tag(req_tag), .req_data(req_data),
    .req_branch(req_branch), .req_branch_taken(req_branch_taken),
    .req_ready(req_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .cdb_branch(cdb_branch), .cdb_branch_taken(cdb_branch_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0h want %0h", nm, obs, exp);
    end
  endtask

  task automatic chk_cdb(input string nm, input logic v, input logic [6:0] t,
                         input logic [31:0] d, input logic b, input logic k);
    chk(nm, {22'd0, cdb_valid, cdb_tag, cdb_data, cdb_branch, cdb_branch_taken},
            {22'd0, v, t, d, b, k});
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]        = rd[i] < wr[i];
      req_tag[i]          = req_valid[i] ? pend[i][rd[i]].tag    : '0;
      req_data[i]         = req_valid[i] ? pend[i][rd[i]].data   : '0;
      req_branch[i]       = req_valid[i] ? pend[i][rd[i]].branch : 1'b0;
      req_branch_taken[i] = req_valid[i] ? pend[i][rd[i]].taken  : 1'b0;
    end
  endtask

  task automatic push(input int u, input logic [6:0] t, input logic [31:0] d,
                      input logic b, input logic k);
    pend[u][wr[u]] = '{tag: t, data: d, branch: b, taken: k};
    wr[u]++;
    drive();
  endtask

  task automatic tick();
    logic [N-1:0] acc;
    acc = req_valid & req_ready;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) if (acc[i]) rd[i]++;
    drive();
  endtask

  logic [6:0]  sb_tag  [6];
  logic [31:0] sb_data [6];
  int          seen;

  initial begin
    for (int i = 0; i < N; i++) begin wr[i] = 0; rd[i] = 0; end
    rst = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    chk("por_ready", req_ready, 4'b0000);
    chk_cdb("por_cdb", 0, 0, 0, 0, 0);
    #3 rst = 1'b1;
    #1 chk("por_release_ready", req_ready, 4'b1111);
    tick();
    chk_cdb("por_idle", 0, 0, 0, 0, 0);

    // single result from the integer unit: broadcast two edges after presenting
    push(REQ_INT, 7'h05, 32'h0000_00AA, 0, 0);
    tick(); chk_cdb("single_k", 0, 0, 0, 0, 0);
    tick(); chk_cdb("single_k1", 1, 7'h05, 32'hAA, 0, 0);
    tick(); chk_cdb("single_done", 0, 0, 0, 0, 0);

    push(REQ_INT, 7'h05, 32'h105, 0, 0);
    push(REQ_INT, 7'h06, 32'h106, 0, 0);
    push(REQ_INT, 7'h07, 32'h107, 0, 0);
    tick(); chk_cdb("b2b_0", 0, 0, 0, 0, 0);
    chk("b2b_ready0", req_ready[0], 1'b1);
    tick(); chk_cdb("b2b_05", 1, 7'h05, 32'h105, 0, 0);
    tick(); chk_cdb("b2b_06", 1, 7'h06, 32'h106, 0, 0);
    tick(); chk_cdb("b2b_07", 1, 7'h07, 32'h107, 0, 0);
    tick(); chk_cdb("b2b_done", 0, 0, 0, 0, 0);

    // mid-stream reset with buffers 0 and 2 full (ptr is 1 here)
    push(REQ_INT,  7'h60, 32'hE0, 0, 0);
    push(REQ_MULT, 7'h62, 32'hE2, 0, 0);
    tick(); chk("rst_pre_ready", req_ready, 4'b1110);
    tick(); chk_cdb("rst_pre_cdb", 1, 7'h62, 32'hE2, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < N; i++) rd[i] = wr[i];
    drive();
    #1;
    chk_cdb("rst_low_cdb", 0, 0, 0, 0, 0);
    chk("rst_low_ready", req_ready, 4'b0000);
    tick(); chk_cdb("rst_low_cdb2", 0, 0, 0, 0, 0);
    chk("rst_low_ready2", req_ready, 4'b0000);
    #3 rst = 1'b1;
    #1 chk("rst_rel_ready", req_ready, 4'b1111);
    tick(); chk_cdb("rst_no_stale1", 0, 0, 0, 0, 0);
    tick(); chk_cdb("rst_no_stale2", 0, 0, 0, 0, 0);

    // round robin from ptr 0
    push(REQ_INT,  7'h10, 32'h110, 0, 0);
    push(REQ_LW,   7'h11, 32'h111, 0, 0);
    push(REQ_MULT, 7'h12, 32'h112, 0, 0);
    push(REQ_DIV,  7'h13, 32'h113, 0, 0);
    tick(); chk_cdb("rr_load", 0, 0, 0, 0, 0);
    chk("rr_ready_a", req_ready, 4'b0001);
    tick(); chk_cdb("rr_10", 1, 7'h10, 32'h110, 0, 0);
    chk("rr_ready_b", req_ready, 4'b0011);
    tick(); chk_cdb("rr_11", 1, 7'h11, 32'h111, 0, 0);
    chk("rr_ready_c", req_ready, 4'b0111);
    tick(); chk_cdb("rr_12", 1, 7'h12, 32'h112, 0, 0);
    chk("rr_ready_d", req_ready, 4'b1111);
    tick(); chk_cdb("rr_13", 1, 7'h13, 32'h113, 0, 0);
    tick(); chk_cdb("rr_done", 0, 0, 0, 0, 0);

    // ptr must be back at 0: unit 0 wins over unit 2, leaving ptr at 3
    push(REQ_INT,  7'h50, 32'h150, 0, 0);
    push(REQ_MULT, 7'h52, 32'h152, 0, 0);
    tick();
    tick(); chk_cdb("ptr0_first", 1, 7'h50, 32'h150, 0, 0);
    tick(); chk_cdb("ptr0_second", 1, 7'h52, 32'h152, 0, 0);
    tick(); chk_cdb("ptr0_done", 0, 0, 0, 0, 0);

    // wrap: units 1 and 3 stream continuously from ptr 3
    for (int k = 1; k <= 3; k++) begin
      push(REQ_LW,  7'h60 + 7'(k), 32'h160 + k, 0, 0);
      push(REQ_DIV, 7'h70 + 7'(k), 32'h170 + k, 0, 0);
    end
    tick();
    tick(); chk_cdb("wrap_3a", 1, 7'h71, 32'h171, 0, 0);
    tick(); chk_cdb("wrap_1a", 1, 7'h61, 32'h161, 0, 0);
    tick(); chk_cdb("wrap_3b", 1, 7'h72, 32'h172, 0, 0);
    tick(); chk_cdb("wrap_1b", 1, 7'h62, 32'h162, 0, 0);
    tick(); chk_cdb("wrap_3c", 1, 7'h73, 32'h173, 0, 0);
    tick(); chk_cdb("wrap_1c", 1, 7'h63, 32'h163, 0, 0);
    tick(); chk_cdb("wrap_done", 0, 0, 0, 0, 0);

    // branch outcome; taken is masked when branch is clear
    push(REQ_INT, 7'h21, 32'h221, 1, 1);
    push(REQ_INT, 7'h22, 32'h222, 0, 1);
    tick();
    tick(); chk_cdb("br_taken", 1, 7'h21, 32'h221, 1, 1);
    tick(); chk_cdb("br_masked", 1, 7'h22, 32'h222, 0, 0);
    tick(); chk_cdb("br_done", 0, 0, 0, 0, 0);

    // backpressure: unit 2 holds 0x33 while its buffer is still occupied (ptr 1)
    push(REQ_INT,  7'h80, 32'h180, 0, 0);
    push(REQ_INT,  7'h90, 32'h190, 0, 0);
    push(REQ_LW,   7'h81, 32'h181, 0, 0);
    push(REQ_LW,   7'h91, 32'h191, 0, 0);
    push(REQ_MULT, 7'h82, 32'h182, 0, 0);
    push(REQ_MULT, 7'h33, 32'hDEAD_BEEF, 0, 0);
    sb_tag[0] = 7'h81; sb_data[0] = 32'h181;
    sb_tag[1] = 7'h82; sb_data[1] = 32'h182;
    sb_tag[2] = 7'h80; sb_data[2] = 32'h180;
    sb_tag[3] = 7'h91; sb_data[3] = 32'h191;
    sb_tag[4] = 7'h33; sb_data[4] = 32'hDEAD_BEEF;
    sb_tag[5] = 7'h90; sb_data[5] = 32'h190;
    tick();
    chk("bp_stall_ready", req_ready, 4'b1010);
    chk("bp_hold_tag", req_tag[2], 7'h33);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (cdb_valid) begin
        if (seen < 6)
          chk($sformatf("bp_sb%0d", seen), {cdb_tag, cdb_data}, {sb_tag[seen], sb_data[seen]});
        seen++;
      end
    end
    chk("bp_count", seen, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Shares the single Common Data Bus among the execution units (integer, load, multiplier, divider). Each unit hands its finished result over a valid/ready handshake into a one-entry holding buffer. A round-robin arbiter picks at most one occupied buffer per cycle and drives it onto the registered CDB outputs. Those outputs feed the dispatcher, tag FIFO, register status table and issue queues.

## Interface
Parameters:
- NUM_REQ, 4, number of requesting execution units
- TAG_W, 7, CDB tag width
- DATA_W, 32, CDB data width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset; asynchronous, active-low
- req_valid  in  NUM_REQ  unit i has a result
- req_tag  in  NUM_REQ x TAG_W  result tag per unit
- req_data  in  NUM_REQ x DATA_W  result value per unit
- req_branch  in  NUM_REQ  result is a resolved branch
- req_branch_taken  in  NUM_REQ  branch outcome: 1 = taken, 0 = not taken
- req_ready  out  NUM_REQ  unit i may present a result this cycle
- cdb_valid  out  1  CDB carries a result this cycle
- cdb_tag  out  TAG_W  broadcast tag
- cdb_data  out  DATA_W  broadcast value
- cdb_branch  out  1  broadcast is a branch resolution
- cdb_branch_taken  out  1  branch outcome

## Operation
- Per unit i, buf_valid[i] plus a holding register for tag, data, branch and taken.
- Accept: req_valid[i] & req_ready[i] at a rising edge loads buffer i and sets buf_valid[i].
- Grant: combinational round-robin over buf_valid, starting the search at ptr, wrapping modulo NUM_REQ. At most one grant per cycle.
- req_ready[i] = ~buf_valid[i] | grant[i]. This allows back-to-back results from a lone unit.
- Simultaneous grant and accept on the same unit: the buffer keeps buf_valid = 1 and takes the new result. The old result goes to the CDB registers.
- On a grant to unit g, the CDB registers load buffer g and cdb_valid becomes 1. ptr becomes (g+1) mod NUM_REQ.
- With no grant: cdb_valid, cdb_tag, cdb_data, cdb_branch and cdb_branch_taken load 0, and ptr holds.
- cdb_branch_taken is forced to 0 whenever cdb_branch = 0.
- A unit holding req_valid while req_ready = 0 must keep its tag, data, branch and taken stable. The arbiter samples them only at the accepting edge.
- Fairness: an occupied buffer is granted within NUM_REQ cycles.
- Reset (rst low, any time): all buf_valid = 0, ptr = 0, every CDB output = 0, req_ready = 0 while rst is low. An in-flight buffered result is discarded.
- After rst deasserts, req_ready = all ones from the first cycle.

## Timing
- Latency: a result accepted at edge k is granted in cycle k+1 if it wins. It is visible on the CDB after edge k+1, in cycle k+1..k+2.
- cdb_valid is high for exactly one cycle per result. There are no duplicate or dropped results.
- Throughput: one CDB result per cycle total. Each unit can sustain one per cycle when it is the only requester.
- All CDB outputs are register outputs. req_ready is combinational from buf_valid and the grant only, with no path from req_valid.

## Structure
- Shared package cdb_pkg:
  - cdb_result_t struct {tag, data, branch, taken}
  - unit index constants REQ_INT = 0, REQ_LW = 1, REQ_MULT = 2, REQ_DIV = 3
- Sub-module rr_arbiter:
  - combinational priority picker, parameter N
  - inputs: request vector and ptr
  - outputs: one-hot grant and encoded winner index
- The top level holds the buffers, ptr and CDB registers.

## Test plan
1. **Reset:** drive rst low mid-stream with buffers 0 and 2 full. Required: all CDB outputs 0 and req_ready = 0000 while low. After release, no stale broadcast and req_ready = 1111.
2. **Single unit:** unit 0 presents tag 0x05 with data 0x0000_00AA. Required: cdb_valid high one cycle, two edges later, tag 0x05, data 0xAA. Back-to-back tags 0x05, 0x06, 0x07 from unit 0 appear on consecutive cycles.
3. **Round-robin:** all four units present tags 0x10..0x13 in the same cycle with ptr = 0. Required: CDB order 0x10, 0x11, 0x12, 0x13 on four consecutive cycles, ptr = 0 afterwards. req_ready[3] stays low until its grant cycle.
4. **Wrap and fairness:** with ptr = 3, units 1 and 3 request continuously. Required: alternating grants 3, 1, 3, 1, and no unit waits more than 4 cycles.
5. **Branch:** unit 0 presents branch = 1, taken = 1, tag 0x21, then branch = 0, taken = 1, tag 0x22. Required: first broadcast cdb_branch = 1, cdb_branch_taken = 1; second cdb_branch = 0, cdb_branch_taken = 0.
6. **Backpressure stability:** unit 2 is stalled behind units 0 and 1, holding tag 0x33 and data 0xDEAD_BEEF. Required: broadcast exactly once with those exact values, and a scoreboard confirms no duplicate or dropped result.
